// File: rtl/osiris_i_prog_loader_if.sv
// Write port between the serial program loader and osiris_i_mem.
// The loader drives request/address/data; the memory answers with a grant.
interface osiris_i_prog_loader_if #(
    parameter int ADDR_W = 9
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_gnt_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_gnt_i
    );
endinterface

// File: rtl/osiris_i_prog_loader.sv
// Serial program loader: receives 64-bit addr/data frames on GPIO pins and issues
// word writes into osiris_i_mem, holding the core in reset while a load is active.
module osiris_i_prog_loader #(
    parameter int ADDR_W      = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          spi_sclk_i,
    input  logic                          spi_cs_ni,
    input  logic                          spi_mosi_i,
    input  logic                          load_mode_i,
    osiris_i_prog_loader_if.master        mem,
    output logic                          core_rst_no,
    output logic                          busy_o,
    output logic                          err_o,
    output logic [15:0]                   word_cnt_o
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] sclkSync_q;
    logic [SYNC_STAGES-1:0] csSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic [SYNC_STAGES-1:0] loadSync_q;
    logic                   sclkPrev_q;
    logic                   loadPrev_q;

    state_t                 st_q;
    logic [6:0]             bitCnt_q;
    logic [63:0]            shift_q;
    logic                   memReq_q;
    logic [ADDR_W-1:0]      holdAddr_q;
    logic [31:0]            holdData_q;
    logic                   err_q;
    logic [15:0]            wordCnt_q;
    logic                   coreRstN_q;

    logic sclkRise;
    logic csN;
    logic mosi;
    logic loadMode;
    logic loadRise;
    logic busy;
    logic grant;
    logic frameDone;
    logic frameBad;
    logic overrun;
    logic frameLoad;
    logic frameErr;
    logic abortErr;

    assign sclkRise = sclkSync_q[SYNC_STAGES-1] & ~sclkPrev_q;
    assign csN      = csSync_q[SYNC_STAGES-1];
    assign mosi     = mosiSync_q[SYNC_STAGES-1];
    assign loadMode = loadSync_q[SYNC_STAGES-1];
    assign loadRise = loadMode & ~loadPrev_q;
    assign busy     = loadMode | memReq_q | (st_q == SHIFT);
    assign grant    = memReq_q & mem.mem_gnt_i;

    // Frame is judged one cycle after its 64th bit lands; a grant in that same
    // cycle frees the holding register, so it is not counted as an overrun.
    always_comb begin
        frameDone = 1'b0;
        frameBad  = 1'b0;
        overrun   = 1'b0;
        frameLoad = 1'b0;
        frameErr  = 1'b0;
        abortErr  = 1'b0;
        frameDone = loadMode && (st_q == SHIFT) && (bitCnt_q == 7'd64);
        frameBad  = (shift_q[33:32] != 2'b00) || (shift_q[63:ADDR_W+34] != '0);
        overrun   = memReq_q & ~mem.mem_gnt_i;
        frameLoad = frameDone & ~frameBad & ~overrun;
        frameErr  = frameDone & (frameBad | overrun);
        abortErr  = loadMode && (st_q == SHIFT) && !frameDone && csN && (bitCnt_q != 7'd0);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            loadSync_q <= '0;
            sclkPrev_q <= 1'b0;
            loadPrev_q <= 1'b0;
            st_q       <= IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            memReq_q   <= 1'b0;
            holdAddr_q <= '0;
            holdData_q <= '0;
            err_q      <= 1'b0;
            wordCnt_q  <= '0;
            coreRstN_q <= 1'b0;
        end else begin
            sclkSync_q <= (sclkSync_q << 1) | SYNC_STAGES'(spi_sclk_i);
            csSync_q   <= (csSync_q << 1)   | SYNC_STAGES'(spi_cs_ni);
            mosiSync_q <= (mosiSync_q << 1) | SYNC_STAGES'(spi_mosi_i);
            loadSync_q <= (loadSync_q << 1) | SYNC_STAGES'(load_mode_i);
            sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
            loadPrev_q <= loadMode;
            coreRstN_q <= ~busy;

            if (grant) begin
                memReq_q <= 1'b0;
                if (wordCnt_q != 16'hFFFF) begin
                    wordCnt_q <= wordCnt_q + 16'd1;
                end
            end
            if (frameLoad) begin
                memReq_q   <= 1'b1;
                holdAddr_q <= shift_q[ADDR_W+33:34];
                holdData_q <= shift_q[31:0];
            end

            // A fresh load session wipes the status seen by the previous one.
            if (loadRise) begin
                err_q     <= 1'b0;
                wordCnt_q <= '0;
            end else if (frameErr || abortErr) begin
                err_q <= 1'b1;
            end

            if (!loadMode) begin
                st_q     <= IDLE;
                bitCnt_q <= '0;
            end else begin
                case (st_q)
                    IDLE: begin
                        if (!csN) begin
                            st_q     <= SHIFT;
                            bitCnt_q <= '0;
                        end
                    end
                    SHIFT: begin
                        if (frameDone) begin
                            bitCnt_q <= '0;
                            if (csN) begin
                                st_q <= IDLE;
                            end
                        end else if (csN) begin
                            st_q     <= IDLE;
                            bitCnt_q <= '0;
                        end else if (sclkRise) begin
                            shift_q  <= {shift_q[62:0], mosi};
                            bitCnt_q <= bitCnt_q + 7'd1;
                        end
                    end
                    default: begin
                        st_q     <= IDLE;
                        bitCnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign mem.mem_req_o   = memReq_q;
    assign mem.mem_addr_o  = holdAddr_q;
    assign mem.mem_wdata_o = holdData_q;
    assign core_rst_no     = coreRstN_q;
    assign busy_o          = busy;
    assign err_o           = err_q;
    assign word_cnt_o      = wordCnt_q;

endmodule

// File: tb/tb_osiris_i_prog_loader.sv
// Scoreboard bench for osiris_i_prog_loader: frames are driven on the serial pins,
// expected writes are queued from an address-rule model and popped by a write monitor.
module tb_osiris_i_prog_loader;

    localparam int ADDR_W = 9;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        csN = 1'b1;
    logic        mosi = 1'b0;
    logic        loadMode = 1'b0;
    logic        coreRstN;
    logic        busy;
    logic        err;
    logic [15:0] wordCnt;

    wr_t expQ[$];
    wr_t expItem;
    int  testCount = 0;
    int  failCount = 0;
    int  expWordCnt = 0;
    logic expErr = 1'b0;
    int  gntMode = 0;

    osiris_i_prog_loader_if #(.ADDR_W(ADDR_W)) memIf ();

    osiris_i_prog_loader #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .spi_sclk_i  (sclk),
        .spi_cs_ni   (csN),
        .spi_mosi_i  (mosi),
        .load_mode_i (loadMode),
        .mem         (memIf.master),
        .core_rst_no (coreRstN),
        .busy_o      (busy),
        .err_o       (err),
        .word_cnt_o  (wordCnt)
    );

    always #5 clk = ~clk;

    // Grant is changed just after each rising edge so it is stable at both edges.
    initial memIf.mem_gnt_i = 1'b0;
    always @(posedge clk) begin
        #2;
        case (gntMode)
            1:       memIf.mem_gnt_i = 1'b1;
            2:       memIf.mem_gnt_i = ($urandom_range(0, 3) == 0);
            default: memIf.mem_gnt_i = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every accepted write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && memIf.mem_req_o && memIf.mem_gnt_i) begin
            if (expQ.size() == 0) begin
                testCount++;
                failCount++;
                $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, expected no write",
                         memIf.mem_addr_o, memIf.mem_wdata_o);
            end else begin
                expItem = expQ.pop_front();
                checkOutput("writeAddr", 64'(memIf.mem_addr_o), 64'(expItem.addr));
                checkOutput("writeData", 64'(memIf.mem_wdata_o), 64'(expItem.data));
            end
        end
    end

    // Reference rule: word aligned and inside the 2^ADDR_W-word memory.
    function automatic bit addrValid(input logic [31:0] addr);
        return (addr % 4 == 0) && (64'(addr) < 64'(4) * (64'(1) << ADDR_W));
    endfunction

    task automatic modelFrame(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        if (addrValid(addr)) begin
            w.addr = ADDR_W'(addr / 4);
            w.data = data;
            expQ.push_back(w);
            expWordCnt++;
        end else begin
            expErr = 1'b1;
        end
    endtask

    task automatic sendBit(input logic b);
        sclk = 1'b0;
        mosi = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic csLow();
        @(negedge clk);
        csN = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic csHigh();
        @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        csN = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input int nBits, input bit modelIt);
        logic [63:0] frame;
        frame = {addr, data};
        if (modelIt && nBits == 64) modelFrame(addr, data);
        for (int i = 0; i < nBits; i++) sendBit(frame[63-i]);
    endtask

    task automatic loadOff();
        @(negedge clk);
        loadMode = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("busyFall", 64'(busy), 64'd0);
        checkOutput("coreRstStillLow", 64'(coreRstN), 64'd0);
        @(posedge clk); #1;
        checkOutput("coreRstRise", 64'(coreRstN), 64'd1);
    endtask

    task automatic loadOn();
        @(negedge clk);
        loadMode = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("errBeforeClear", 64'(err), 64'(expErr));
        checkOutput("busyRise", 64'(busy), 64'd1);
        @(posedge clk); #1;
        expErr = 1'b0;
        expWordCnt = 0;
        checkOutput("errCleared", 64'(err), 64'd0);
        checkOutput("wordCntCleared", 64'(wordCnt), 64'd0);
        checkOutput("coreRstFall", 64'(coreRstN), 64'd0);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((expQ.size() != 0 || memIf.mem_req_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainQueueEmpty", 64'(expQ.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] frame;
        logic [31:0] a;
        int n;

        repeat (3) @(negedge clk);
        checkOutput("resetReq", 64'(memIf.mem_req_o), 64'd0);
        checkOutput("resetAddr", 64'(memIf.mem_addr_o), 64'd0);
        checkOutput("resetData", 64'(memIf.mem_wdata_o), 64'd0);
        checkOutput("resetCoreRst", 64'(coreRstN), 64'd0);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetErr", 64'(err), 64'd0);
        checkOutput("resetWordCnt", 64'(wordCnt), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idleCoreRunning", 64'(coreRstN), 64'd1);
        loadOn();
        gntMode = 1;

        // Single frame with a latency check on the 64th bit.
        csLow();
        modelFrame(32'h0000_0010, 32'hDEAD_BEEF);
        frame = {32'h0000_0010, 32'hDEAD_BEEF};
        for (int i = 0; i < 63; i++) sendBit(frame[63-i]);
        sclk = 1'b0;
        mosi = frame[0];
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        @(posedge clk); #1;
        checkOutput("reqAtE0", 64'(memIf.mem_req_o), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("reqAtE2", 64'(memIf.mem_req_o), 64'd0);
        @(posedge clk); #1;
        checkOutput("reqAtE3", 64'(memIf.mem_req_o), 64'd1);
        checkOutput("addrAtE3", 64'(memIf.mem_addr_o), 64'd4);
        checkOutput("dataAtE3", 64'(memIf.mem_wdata_o), 64'hDEAD_BEEF);
        @(posedge clk); #1;
        checkOutput("reqAtE4", 64'(memIf.mem_req_o), 64'd0);
        checkOutput("wordCntSingle", 64'(wordCnt), 64'(expWordCnt));
        repeat (3) @(negedge clk);
        csHigh();
        checkOutput("errSingle", 64'(err), 64'd0);
        loadOff();
        loadOn();

        // Misaligned and out-of-range addresses are dropped.
        csLow();
        applyStimulus(32'h0000_0002, $urandom, 64, 1'b1);
        csHigh();
        checkOutput("errMisaligned", 64'(err), 64'(expErr));
        checkOutput("reqMisaligned", 64'(memIf.mem_req_o), 64'd0);
        loadOff();
        loadOn();
        csLow();
        applyStimulus(32'(4 << ADDR_W), $urandom, 64, 1'b1);
        csHigh();
        checkOutput("errOutOfRange", 64'(err), 64'(expErr));
        checkOutput("wordCntBad", 64'(wordCnt), 64'd0);
        loadOff();
        loadOn();

        // Early chip-select release, then a normal frame.
        csLow();
        applyStimulus(32'h0000_0040, 32'h1234_5678, 40, 1'b0);
        expErr = 1'b1;
        csHigh();
        checkOutput("errEarlyRelease", 64'(err), 64'(expErr));
        csLow();
        applyStimulus(32'h0000_0044, 32'hCAFE_F00D, 64, 1'b1);
        csHigh();
        waitIdle();
        checkOutput("wordCntAfterAbort", 64'(wordCnt), 64'(expWordCnt));
        loadOff();
        loadOn();

        // Three back-to-back frames with the grant stalled across the second.
        gntMode = 0;
        csLow();
        applyStimulus(32'h0000_0100, 32'hAAAA_0001, 64, 1'b1);
        applyStimulus(32'h0000_0104, 32'hAAAA_0002, 64, 1'b0);
        expErr = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("errOverrun", 64'(err), 64'(expErr));
        checkOutput("reqPendingOverrun", 64'(memIf.mem_req_o), 64'd1);
        checkOutput("addrPendingOverrun", 64'(memIf.mem_addr_o), 64'h40);
        gntMode = 1;
        applyStimulus(32'h0000_0108, 32'hAAAA_0003, 64, 1'b1);
        csHigh();
        waitIdle();
        checkOutput("wordCntBackToBack", 64'(wordCnt), 64'(expWordCnt));
        loadOff();
        loadOn();

        // Randomised frames with a random grant.
        gntMode = 2;
        for (int f = 0; f < 10; f++) begin
            csLow();
            n = $urandom_range(1, 2);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 5))
                    0: a = ($urandom_range(0, (1 << ADDR_W) - 1) << 2) | $urandom_range(1, 3);
                    1: a = ($urandom & 32'hFFFF_FFFC) | (32'd1 << $urandom_range(ADDR_W + 2, 31));
                    default: a = $urandom_range(0, (1 << ADDR_W) - 1) << 2;
                endcase
                applyStimulus(a, $urandom, 64, 1'b1);
            end
            csHigh();
        end
        waitIdle();
        checkOutput("errRandom", 64'(err), 64'(expErr));
        checkOutput("wordCntRandom", 64'(wordCnt), 64'(expWordCnt));

        // Asynchronous reset while a request is pending.
        gntMode = 0;
        csLow();
        applyStimulus(32'h0000_0200, 32'h5555_AAAA, 64, 1'b1);
        n = 0;
        while (!memIf.mem_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reqBeforeReset", 64'(memIf.mem_req_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expQ.delete();
        expWordCnt = 0;
        expErr = 1'b0;
        checkOutput("asyncResetReq", 64'(memIf.mem_req_o), 64'd0);
        checkOutput("asyncResetCoreRst", 64'(coreRstN), 64'd0);
        checkOutput("asyncResetBusy", 64'(busy), 64'd0);
        checkOutput("asyncResetWordCnt", 64'(wordCnt), 64'd0);
        csN = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        gntMode = 1;
        repeat (30) @(negedge clk);
        checkOutput("postResetReq", 64'(memIf.mem_req_o), 64'd0);
        checkOutput("postResetWordCnt", 64'(wordCnt), 64'd0);
        checkOutput("postResetErr", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
